// File: rtl/mii_tx_arbiter_if.sv
// mii_tx_arbiter_if: source-side request/start/data bundle between frame formers and the MII arbiter
interface mii_tx_arbiter_if #(
    parameter int NUM_CH = 4
) ();
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   start;
    logic [NUM_CH-1:0]   src_tx_en;
    logic [4*NUM_CH-1:0] src_tx_d;
    modport master (output req, output src_tx_en, output src_tx_d, input start);
    modport slave (input req, input src_tx_en, input src_tx_d, output start);
endinterface

// File: rtl/mii_tx_arbiter.sv
// mii_tx_arbiter: N-channel MII transmit arbiter (round-robin or fixed priority) with start timeout and
// enforced inter-frame gap; defining MII_ARB_WATCHDOG_EN adds the frame-length watchdog (TRUNC, err_long),
// otherwise err_long is constant low.
module mii_tx_arbiter #(
    parameter int NUM_CH            = 4,
    parameter int PRIO_MODE         = 0,
    parameter int IFG_NIBBLES       = 24,
    parameter int START_TIMEOUT     = 16,
    parameter int MAX_FRAME_NIBBLES = 3052
) (
    input  logic                      clock,
    input  logic                      aclr_n,
    mii_tx_arbiter_if.slave           src,
    output logic                      TX_EN,
    output logic [3:0]                TX_D,
    output logic                      busy,
    output logic [$clog2(NUM_CH)-1:0] active_ch,
    output logic                      frame_done,
    output logic                      err_timeout,
    output logic                      err_long
);
    localparam int CW = $clog2(NUM_CH);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam int IW = $clog2(IFG_NIBBLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [IW-1:0] I_LAST = IW'(IFG_NIBBLES - 1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_EN, SEND, IFG
`ifdef MII_ARB_WATCHDOG_EN
        , TRUNC
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] win;
    logic [CW-1:0] k;
    logic [TW-1:0] tcnt;
    logic [IW-1:0] icnt;
    logic          cur_en;
    logic [3:0]    cur_d;

`ifdef MII_ARB_WATCHDOG_EN
    localparam int NW = $clog2(MAX_FRAME_NIBBLES + 1);
    localparam logic [NW-1:0] N_MAX = NW'(MAX_FRAME_NIBBLES);
    logic [NW-1:0] ncnt;
`else
    assign err_long = (MAX_FRAME_NIBBLES < 0);
`endif

    assign cur_en = src.src_tx_en[active_ch];
    assign cur_d  = src.src_tx_d[{active_ch, 2'b00} +: 4];
    assign busy   = (state != IDLE);

    // Winner select: later loop iterations have higher priority, so iterate from lowest to highest priority
    always_comb begin
        win = '0;
        k   = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            k = (PRIO_MODE != 0) ? CW'(i - 1) : CW'((int'(rr_ptr) + i) % NUM_CH);
            if (src.req[k]) win = k;
        end
    end

    // Arbitration FSM with registered MII outputs and one-cycle status pulses
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= IDLE;
            src.start   <= '0;
            active_ch   <= '0;
            rr_ptr      <= CW'(NUM_CH - 1);
            TX_EN       <= 1'b0;
            TX_D        <= 4'h0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            tcnt        <= '0;
            icnt        <= '0;
`ifdef MII_ARB_WATCHDOG_EN
            err_long    <= 1'b0;
            ncnt        <= '0;
`endif
        end else begin
            src.start   <= '0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
`ifdef MII_ARB_WATCHDOG_EN
            err_long    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|src.req) begin
                        src.start <= NUM_CH'(1) << win;
                        active_ch <= win;
                        state     <= START;
                    end
                end
                START: begin
                    tcnt  <= '0;
                    state <= WAIT_EN;
                end
                WAIT_EN: begin
                    if (cur_en) begin
                        TX_EN <= 1'b1;
                        TX_D  <= cur_d;
`ifdef MII_ARB_WATCHDOG_EN
                        ncnt  <= NW'(1);
`endif
                        state <= SEND;
                    end else if (tcnt == T_LAST) begin
                        err_timeout <= 1'b1;
                        icnt        <= '0;
                        state       <= IFG;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SEND: begin
                    if (!cur_en) begin
                        TX_EN      <= 1'b0;
                        TX_D       <= 4'h0;
                        frame_done <= 1'b1;
                        rr_ptr     <= active_ch;
                        icnt       <= '0;
                        state      <= IFG;
                    end
`ifdef MII_ARB_WATCHDOG_EN
                    else if (ncnt == N_MAX) begin
                        TX_EN    <= 1'b0;
                        TX_D     <= 4'h0;
                        err_long <= 1'b1;
                        state    <= TRUNC;
                    end else begin
                        TX_D <= cur_d;
                        ncnt <= ncnt + 1'b1;
                    end
`else
                    else begin
                        TX_D <= cur_d;
                    end
`endif
                end
`ifdef MII_ARB_WATCHDOG_EN
                TRUNC: begin
                    if (!cur_en) begin
                        rr_ptr <= active_ch;
                        icnt   <= '0;
                        state  <= IFG;
                    end
                end
`endif
                IFG: begin
                    if (icnt == I_LAST) state <= IDLE;
                    else icnt <= icnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mii_tx_arbiter.sv
// tb_mii_tx_arbiter: directed scoreboard bench for mii_tx_arbiter (round-robin and fixed-priority instances)
module tb_mii_tx_arbiter;
    localparam int MAXN = 3052;

    logic       clock;
    logic       aclr_n;
    logic       r_tx_en, r_busy, r_done, r_errt, r_errl;
    logic [3:0] r_tx_d;
    logic [1:0] r_ach;
    logic       p_tx_en, p_busy, p_done, p_errt, p_errl;
    logic [3:0] p_tx_d;
    logic [1:0] p_ach;

    int checks = 0;
    int errors = 0;
    int gq[$];
    int pgq[$];
    int dq[$];
    int low = 0;
    bit seen = 0;
    logic prev_en = 0;
    int n_done = 0, n_tout = 0, n_long = 0;
    int c, done0;

    mii_tx_arbiter_if #(.NUM_CH(4)) rif ();
    mii_tx_arbiter_if #(.NUM_CH(4)) pif ();

    mii_tx_arbiter #(.NUM_CH(4), .PRIO_MODE(0)) u_rr (
        .clock(clock), .aclr_n(aclr_n), .src(rif),
        .TX_EN(r_tx_en), .TX_D(r_tx_d), .busy(r_busy), .active_ch(r_ach),
        .frame_done(r_done), .err_timeout(r_errt), .err_long(r_errl)
    );

    mii_tx_arbiter #(.NUM_CH(4), .PRIO_MODE(1)) u_prio (
        .clock(clock), .aclr_n(aclr_n), .src(pif),
        .TX_EN(p_tx_en), .TX_D(p_tx_d), .busy(p_busy), .active_ch(p_ach),
        .frame_done(p_done), .err_timeout(p_errt), .err_long(p_errl)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Output monitor: grants and forwarded nibbles are popped from the scoreboard queues
    always @(negedge clock) begin
        if (!aclr_n) begin
            seen    <= 0;
            low     <= 0;
            prev_en <= 1'b0;
        end else begin
            if (|rif.start) chk("rr_grant", rif.start, (gq.size() != 0) ? (32'd1 << gq.pop_front()) : 32'd0);
            if (|pif.start) chk("prio_grant", pif.start, (pgq.size() != 0) ? (32'd1 << pgq.pop_front()) : 32'd0);
            if (r_tx_en) chk("tx_d", r_tx_d, (dq.size() != 0) ? dq.pop_front() : 32'hDEAD);
            else chk("tx_d_idle", r_tx_d, 0);
            if (r_tx_en && !prev_en && seen) chk("ifg_gap_ge27", (low >= 27) ? 27 : low, 27);
            low     <= r_tx_en ? 0 : low + 1;
            seen    <= seen | r_tx_en;
            prev_en <= r_tx_en;
            n_done  <= n_done + int'(r_done);
            n_tout  <= n_tout + int'(r_errt);
            n_long  <= n_long + int'(r_errl);
        end
    end

    task automatic wait_start(input bit p, input int ch, input int lim, output int cyc);
        logic got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < lim) begin
            @(posedge clock);
            #1;
            cyc++;
            got = p ? pif.start[ch] : rif.start[ch];
        end
        chk("start_seen", got, 1);
    endtask

    task automatic send(input int ch, input int n, input bit toggle, input logic [3:0] req_after);
        int cyc;
        wait_start(0, ch, 100, cyc);
        rif.req = req_after;
        @(posedge clock);
        #1;
        for (int j = 0; j < n; j++) begin
            rif.src_tx_en[ch] = 1'b1;
            rif.src_tx_d[4*ch +: 4] = 4'(j);
`ifdef MII_ARB_WATCHDOG_EN
            if (j < MAXN) dq.push_back(j & 15);
`else
            dq.push_back(j & 15);
`endif
            if (toggle) begin
                rif.src_tx_en[(ch + 1) % 4] = j[0];
                rif.src_tx_d[4*((ch + 1) % 4) +: 4] = 4'($urandom);
            end
            @(posedge clock);
            #1;
        end
        rif.src_tx_en = '0;
        rif.src_tx_d  = '0;
    endtask

    initial begin
        aclr_n = 1'b0;
        rif.req = '0; rif.src_tx_en = '0; rif.src_tx_d = '0;
        pif.req = '0; pif.src_tx_en = '0; pif.src_tx_d = '0;
        #12;
        chk("rst_tx_en", r_tx_en, 0);
        chk("rst_tx_d", r_tx_d, 0);
        chk("rst_start", rif.start, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_active_ch", r_ach, 0);
        chk("rst_pulses", {r_done, r_errt, r_errl}, 0);
        @(posedge clock);
        #1 aclr_n = 1'b1;

        // fixed priority: 0110 grants 1, then 0111 grants 0
        pgq.push_back(1);
        pif.req = 4'b0110;
        wait_start(1, 1, 20, c);
        chk("prio_active_ch1", p_ach, 1);
        pif.req = 4'b0111;
        @(posedge clock);
        #1 pif.src_tx_en[1] = 1'b1;
        repeat (8) @(posedge clock);
        #1 pif.src_tx_en[1] = 1'b0;
        pgq.push_back(0);
        wait_start(1, 0, 60, c);
        chk("prio_active_ch0", p_ach, 0);
        pif.req = '0;
        @(posedge clock);
        #1 pif.src_tx_en[0] = 1'b1;
        repeat (4) @(posedge clock);
        #1 pif.src_tx_en[0] = 1'b0;
        repeat (30) @(posedge clock);
        #1 chk("prio_idle", p_busy, 0);

        // round-robin with all requests held: 0,1,2,3
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3);
        rif.req = 4'hF;
        send(0, 8, 0, 4'hF);
        send(1, 8, 0, 4'hF);
        send(2, 8, 0, 4'hF);
        send(3, 8, 0, 4'h0);
        repeat (3) @(posedge clock);
        #1 chk("rr_done_cnt", n_done, 4);

        // pointer wrap: after 3, 0101 grants 0 then 2
        gq.push_back(0); gq.push_back(2);
        rif.req = 4'b0101;
        send(0, 6, 0, 4'b0101);
        send(2, 6, 0, 4'b0000);

        // start timeout on channel 1
        gq.push_back(1);
        rif.req = 4'b0010;
        wait_start(0, 1, 60, c);
        rif.req = '0;
        c = 0;
        do begin @(posedge clock); #1; c++; end while (!r_errt && c < 40);
        chk("timeout_latency", c, 17);
        c = 0;
        do begin @(posedge clock); #1; c++; end while (r_busy && c < 60);
        chk("timeout_ifg_len", c, 24);
        chk("timeout_pulses", n_tout, 1);

        // timeout leaves the pointer at 2, so 1111 grants 3; 136-nibble pass-through with a noisy neighbour
        gq.push_back(3);
        rif.req = 4'hF;
        done0 = n_done;
        send(3, 136, 1, 4'h0);
        repeat (3) @(posedge clock);
        #1 chk("pass_done_once", n_done - done0, 1);
        chk("pass_drained", dq.size(), 0);

        // long frame: watchdog truncates (or forwards all without the watchdog); regrant after drop + IFG
        gq.push_back(0);
        gq.push_back(1);
        rif.req = 4'b0001;
        send(0, 4000, 0, 4'b0010);
        wait_start(0, 1, 100, c);
        chk("regrant_delay", c, 26);
`ifdef MII_ARB_WATCHDOG_EN
        chk("err_long_cnt", n_long, 1);
`else
        chk("err_long_cnt", n_long, 0);
`endif
        chk("long_drained", dq.size(), 0);

        // reset in the middle of channel 1's frame
        rif.req = '0;
        @(posedge clock);
        #1;
        for (int j = 0; j < 10; j++) begin
            rif.src_tx_en[1] = 1'b1;
            rif.src_tx_d[7:4] = 4'(j + 5);
            dq.push_back(j + 5);
            @(posedge clock);
            #1;
        end
        chk("pre_rst_tx_en", r_tx_en, 1);
        done0 = n_done;
        #2 aclr_n = 1'b0;
        #1;
        chk("mid_rst_tx_en", r_tx_en, 0);
        chk("mid_rst_tx_d", r_tx_d, 0);
        chk("mid_rst_busy", r_busy, 0);
        chk("mid_rst_active_ch", r_ach, 0);
        dq.delete();
        rif.src_tx_en = '0;
        rif.src_tx_d  = '0;
        repeat (2) @(posedge clock);
        #1 aclr_n = 1'b1;
        chk("no_done_on_rst", n_done - done0, 0);
        gq.push_back(0);
        rif.req = 4'hF;
        send(0, 4, 0, 4'h0);
        repeat (30) @(posedge clock);
        #1;
        chk("grants_drained", gq.size(), 0);
        chk("prio_grants_drained", pgq.size(), 0);
        chk("data_drained", dq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mii_tx_arbiter.md
# mii_tx_arbiter

Parametrised N-channel MII transmit arbiter that sits between the frame formers (ARP answer former, partial-message reporter, and future sources) and the 4-bit PHY transmit pins. It replaces the fixed two-source ad-hoc scheduler with:

- selectable round-robin or fixed-priority arbitration;
- a one-cycle start handshake with a start timeout;
- enforced inter-frame gap;
- an optional frame-length watchdog.

## Interface
Parameters:
- NUM_CH, 4: number of source channels (2..8).
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).
- IFG_NIBBLES, 24: idle nibbles forced after every frame (96 bit times).
- START_TIMEOUT, 16: cycles allowed between start pulse and source asserting tx_en.
- MAX_FRAME_NIBBLES, 3052: watchdog limit, preamble included (1526 bytes × 2).

Ports:
- clock, in, 1: MII transmit clock (25 MHz). All logic on posedge; integration supplies the inverted TX_CLK.
- aclr_n, in, 1: asynchronous active-low reset.
- req, in, NUM_CH: level, source has a frame ready.
- start, out, NUM_CH: one-hot, one-cycle pulse to the granted source.
- src_tx_en, in, NUM_CH: per-source transmit enable.
- src_tx_d, in, 4*NUM_CH: per-source nibble; channel k occupies bits [4k+3:4k].
- TX_EN, out, 1: registered MII enable.
- TX_D, out, 4: registered MII nibble.
- busy, out, 1: high in every state except IDLE.
- active_ch, out, $clog2(NUM_CH): index of the current/last granted channel.
- frame_done, out, 1: one-cycle pulse when the granted source ends its frame normally.
- err_timeout, out, 1: one-cycle pulse on start timeout.
- err_long, out, 1: one-cycle pulse on watchdog truncation.

## Operation
- States: IDLE → START → WAIT_EN → SEND → (TRUNC) → IFG → IDLE.
- **IDLE**
  - If any req bit is set, select a winner g:
    - Round-robin: first set bit searching upward from rr_ptr+1, with wrap.
    - Fixed priority: lowest set index.
  - Assert start[g]; latch active_ch = g; go to START.
- **START**: deassert start; go to WAIT_EN; clear the timeout counter.
- **WAIT_EN**
  - src_tx_en[g] = 1: go to SEND; forward the first nibble.
  - Counter reaches START_TIMEOUT: pulse err_timeout; go to IFG.
  - Deassertion of req[g] is ignored.
- **SEND**
  - TX_EN <= src_tx_en[g]; TX_D <= src_tx_d[g].
  - Nibble counter increments each cycle.
  - On src_tx_en[g] = 0: pulse frame_done; TX_EN <= 0, TX_D <= 0; go to IFG.
  - On rr_ptr update (round-robin), rr_ptr <= g when SEND or TRUNC is exited.
- **TRUNC** (watchdog builds only)
  - Entered when the nibble counter equals MAX_FRAME_NIBBLES.
  - On entry: TX_EN <= 0 and err_long pulses.
  - The source continues but is not forwarded; wait for src_tx_en[g] = 0, then go to IFG.
- **IFG**: count IFG_NIBBLES cycles with TX_EN = 0, then go to IDLE. req is sampled only in IDLE.
- Non-granted sources: src_tx_en and src_tx_d are ignored at all times.
- TX_D is forced to 0 whenever TX_EN is 0.
- Counters are sized $clog2(limit+1). The nibble counter saturates and never wraps.

## Timing
- Reset (aclr_n = 0, asynchronous):
  - TX_EN = 0, TX_D = 0, start = 0, busy = 0, active_ch = 0, all error/done pulses = 0.
  - State IDLE; rr_ptr = NUM_CH-1, so channel 0 wins first.
- Reset mid-frame drops TX_EN immediately. No frame_done is issued.
- Latency:
  - req sampled in IDLE → start high the next edge.
  - src_tx_en/src_tx_d → TX_EN/TX_D: 1 cycle.
- Minimum idle between consecutive frames on TX_EN: IFG_NIBBLES + 3 cycles (end detect, IDLE, START, WAIT_EN ≥ 1).
- If req of several channels changes on the IDLE sampling edge, the value present at that edge decides.

## Configuration
- MII_ARB_WATCHDOG_EN:
  - Defined: nibble counter, TRUNC state and err_long are implemented.
  - Undefined: no length limit, TRUNC is absent, err_long is tied 0, and MAX_FRAME_NIBBLES is unused.

## Test plan
- **Round-robin, NUM_CH=4**: req=4'b1111 held for four frames → grant order 0,1,2,3. TX_EN gaps are ≥ 27 cycles.
- **PRIO_MODE=1**: req=4'b0110, then req=4'b0111 after the first frame → grants 1, then 0.
- **Pass-through**: granted source sends 136 nibbles with a counting pattern → TX_D is identical, delayed 1 cycle. frame_done pulses once. A non-granted src_tx_en toggling has no effect.
- **Timeout**: start issued, source never asserts tx_en → err_timeout pulses 16 cycles after WAIT_EN entry. TX_EN stays 0. Arbiter returns to IDLE after 24 IFG cycles.
- **Watchdog (MII_ARB_WATCHDOG_EN defined)**: source holds tx_en for 4000 nibbles → TX_EN falls after 3052 nibbles and err_long pulses once. No new grant until source tx_en falls + 24 cycles. Without the macro, all 4000 nibbles are forwarded.
- **Reset**: aclr_n pulsed low mid-frame → TX_EN drops the same cycle. After release, the next grant goes to channel 0.
